// File: rtl/adsb_ppm_tx_if.sv
// Register-bus and sample-stream bundle for the ADS-B PPM transmitter.
// master drives the message and levels, slave returns the waveform and status.
interface adsb_ppm_tx_if #(
  parameter int width = 10
);
  logic             ena;
  logic             load;
  logic [31:0]      wdat;
  logic             start;
  logic             long_msg;
  logic [width-1:0] hi_level;
  logic [width-1:0] lo_level;
  logic [width-1:0] logmag;
  logic             env;
  logic             busy;
  logic             done;
  logic [1:0]       wr_ptr;

  modport master (
    output ena, load, wdat, start, long_msg,
    output hi_level, lo_level,
    input  logmag, env, busy, done, wr_ptr
  );

  modport slave (
    input  ena, load, wdat, start, long_msg,
    input  hi_level, lo_level,
    output logmag, env, busy, done, wr_ptr
  );
endinterface

// File: rtl/adsb_ppm_tx.sv
// Mode-S / ADS-B PPM waveform generator: preamble + 1 Mbit/s PPM data.
// Emits a registered logmag stream and on/off envelope for loopback.
module adsb_ppm_tx #(
  parameter int width      = 10,
  parameter int CHIP_CLKS  = 10,
  parameter int TAIL_CHIPS = 8
) (
  input  logic          clk,
  input  logic          reset,
  adsb_ppm_tx_if.slave  bus
);
  localparam int CW = (CHIP_CLKS > 1) ? $clog2(CHIP_CLKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    TAIL
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_chip;
  logic [111:0]     r_sr;
  logic             r_long;
  logic [1:0]       r_wr_ptr;
  logic [width-1:0] r_logmag;
  logic             r_env;
  logic             r_busy;
  logic             r_done;

  // word3 low half is never transmitted, so only its top 16 bits are kept
  logic [31:0]      r_buf [0:2];
  logic [15:0]      r_w3;

  logic             w_idle;
  logic             w_last_clk;
  logic             w_on;
  logic [7:0]       w_data_last;

  assign w_idle      = (r_state == IDLE);
  assign w_last_clk  = (r_cnt == CW'(CHIP_CLKS - 1));
  assign w_data_last = r_long ? 8'd223 : 8'd111;

  // envelope of the chip currently being timed
  always_comb begin
    w_on = 1'b0;
    unique case (r_state)
      PRE:  w_on = (r_chip == 8'd0) || (r_chip == 8'd2) ||
                   (r_chip == 8'd7) || (r_chip == 8'd9);
      DATA: w_on = r_sr[111] ^ r_chip[0];
      default: w_on = 1'b0;
    endcase
  end

  // message buffer: writable only while idle, not cleared by reset
  always_ff @(posedge clk) begin
    if (w_idle && bus.load && !reset) begin
      if (r_wr_ptr == 2'd3) r_w3 <= bus.wdat[31:16];
      else r_buf[r_wr_ptr] <= bus.wdat;
    end
  end

  // transmit sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_chip   <= '0;
      r_sr     <= '0;
      r_long   <= 1'b0;
      r_wr_ptr <= '0;
      r_logmag <= '0;
      r_env    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_idle) begin
        if (bus.load) r_wr_ptr <= r_wr_ptr + 2'd1;
        if (bus.start) begin
          r_sr     <= {r_buf[0], r_buf[1], r_buf[2], r_w3};
          r_long   <= bus.long_msg;
          r_wr_ptr <= '0;
          r_busy   <= 1'b1;
          r_state  <= PRE;
          r_cnt    <= '0;
          r_chip   <= '0;
        end
      end
      if (bus.ena) begin
        r_env    <= w_on;
        r_logmag <= w_on ? bus.hi_level : bus.lo_level;
        if (!w_idle) begin
          if (w_last_clk) begin
            r_cnt  <= '0;
            r_chip <= r_chip + 8'd1;
            unique case (r_state)
              PRE: begin
                if (r_chip == 8'd15) begin
                  r_state <= DATA;
                  r_chip  <= '0;
                end
              end
              DATA: begin
                if (r_chip[0]) r_sr <= {r_sr[110:0], 1'b0};
                if (r_chip == w_data_last) begin
                  r_state <= TAIL;
                  r_chip  <= '0;
                end
              end
              TAIL: begin
                if (r_chip == 8'(TAIL_CHIPS - 1)) begin
                  r_state <= IDLE;
                  r_chip  <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
              default: r_state <= IDLE;
            endcase
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign bus.logmag = r_logmag;
  assign bus.env    = r_env;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.wr_ptr = r_wr_ptr;
endmodule

// File: tb/tb_adsb_ppm_tx.sv
// Randomized bench for adsb_ppm_tx against a chip-table reference model.
// Every clock compares logmag, env, busy, done and wr_ptr.
module tb_adsb_ppm_tx;
  localparam int W    = 10;
  localparam int CHIP = 10;
  localparam int TAIL = 8;

  logic clk;
  logic reset;

  adsb_ppm_tx_if #(.width(W)) bus ();

  adsb_ppm_tx #(
    .width(W),
    .CHIP_CLKS(CHIP),
    .TAIL_CHIPS(TAIL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int n_chk;
  int n_err;

  logic [31:0]  m_buf [0:3];
  logic [1:0]   m_ptr;
  bit           m_busy;
  int           m_e;
  int           m_total;
  bit           m_chips [0:255];
  logic         m_env;
  logic [W-1:0] m_lm;
  logic         m_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_chips(input bit lng);
    int n;
    logic [127:0] msg;
    n = lng ? 112 : 56;
    msg = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
    for (int i = 0; i < 256; i++) m_chips[i] = 1'b0;
    m_chips[0] = 1'b1;
    m_chips[2] = 1'b1;
    m_chips[7] = 1'b1;
    m_chips[9] = 1'b1;
    for (int j = 0; j < n; j++) begin
      m_chips[16 + 2*j] = msg[127 - j];
      m_chips[17 + 2*j] = !msg[127 - j];
    end
    m_total = (16 + 2*n + TAIL) * CHIP;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_e    = 0;
      m_ptr  = 2'd0;
      m_env  = 1'b0;
      m_lm   = '0;
    end else if (m_busy) begin
      if (bus.ena) begin
        m_e++;
        m_env = m_chips[(m_e - 1) / CHIP];
        m_lm  = m_env ? bus.hi_level : bus.lo_level;
        if (m_e == m_total) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else begin
      if (bus.ena) begin
        m_env = 1'b0;
        m_lm  = bus.lo_level;
      end
      if (bus.start) build_chips(bus.long_msg);
      if (bus.load) begin
        m_buf[m_ptr] = bus.wdat;
        m_ptr = m_ptr + 2'd1;
      end
      if (bus.start) begin
        m_ptr  = 2'd0;
        m_busy = 1'b1;
        m_e    = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("logmag", 32'(bus.logmag), 32'(m_lm));
    chk("env", 32'(bus.env), 32'(m_env));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("wr_ptr", 32'(bus.wr_ptr), 32'(m_ptr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ena      = 1'($urandom);
      bus.hi_level = W'($urandom);
      bus.lo_level = W'($urandom);
      step();
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    bus.load = 1'b1;
    bus.wdat = w;
    bus.ena  = 1'($urandom);
    step();
    bus.load = 1'b0;
  endtask

  task automatic run_tx(input bit lng, input int mode, input bit noise,
                        input int rst_at, input bit ld_start,
                        input logic [31:0] ldv);
    int cnt;
    int nb;
    int tot;
    bus.start    = 1'b1;
    bus.long_msg = lng;
    bus.ena      = 1'b1;
    if (ld_start) begin
      bus.load = 1'b1;
      bus.wdat = ldv;
    end
    step();
    bus.start = 1'b0;
    bus.load  = 1'b0;
    tot = m_total;
    nb  = int'(bus.busy);
    cnt = 0;
    while (m_busy && cnt < 20000) begin
      case (mode)
        0: bus.ena = 1'b1;
        1: bus.ena = cnt[0];
        default: bus.ena = ($urandom_range(0, 3) != 0);
      endcase
      bus.hi_level = W'($urandom);
      bus.lo_level = W'($urandom);
      if (noise) begin
        bus.load     = ($urandom_range(0, 3) == 0);
        bus.wdat     = $urandom;
        bus.start    = ($urandom_range(0, 7) == 0);
        bus.long_msg = 1'($urandom);
      end
      if (cnt == rst_at) reset = 1'b1;
      step();
      nb += int'(bus.busy);
      reset     = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      cnt++;
    end
    chk("tx_end", 32'(bus.busy), 32'd0);
    if (mode == 0 && rst_at < 0) chk("duration", nb, tot);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) m_buf[i] = '0;
    m_ptr  = 2'd0;
    m_busy = 1'b0;
    m_e    = 0;
    m_env  = 1'b0;
    m_lm   = '0;
    m_done = 1'b0;
    m_total = 0;
    reset        = 1'b1;
    bus.ena      = 1'b0;
    bus.load     = 1'b0;
    bus.wdat     = '0;
    bus.start    = 1'b0;
    bus.long_msg = 1'b0;
    bus.hi_level = W'(600);
    bus.lo_level = W'(40);
    step();
    step();
    reset = 1'b0;
    idle(3);

    load_word(32'h8D4840D6);
    load_word(32'h202CC371);
    load_word(32'hC32CE057);
    load_word(32'h60981234);
    run_tx(1'b1, 0, 1'b0, -1, 1'b0, 32'd0);
    idle(4);

    load_word(32'hFFFFFFFF);
    load_word(32'h00000000);
    load_word($urandom);
    load_word($urandom);
    run_tx(1'b0, 0, 1'b0, -1, 1'b0, 32'd0);
    idle(4);

    for (int i = 0; i < 4; i++) load_word($urandom);
    run_tx(1'b1, 1, 1'b0, -1, 1'b0, 32'd0);
    idle(4);

    for (int i = 0; i < 4; i++) load_word($urandom);
    run_tx(1'($urandom), 2, 1'b1, -1, 1'b0, 32'd0);
    idle(4);

    run_tx(1'b1, 0, 1'b0, -1, 1'b1, $urandom);
    idle(2);
    run_tx(1'b0, 0, 1'b0, -1, 1'b0, 32'd0);
    idle(2);

    for (int i = 0; i < 5; i++) load_word($urandom);
    chk("ptr_after_5_loads", 32'(bus.wr_ptr), 32'd1);
    for (int i = 0; i < 3; i++) load_word($urandom);

    run_tx(1'b1, 0, 1'b0, 499, 1'b0, 32'd0);
    chk("rst_logmag", 32'(bus.logmag), 32'd0);
    idle(3);
    run_tx(1'b1, 0, 1'b0, -1, 1'b0, 32'd0);
    idle(3);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) load_word($urandom);
      run_tx(1'($urandom), 2, 1'b1, -1, 1'b0, 32'd0);
      idle(5);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/adsb_ppm_tx.md
Name: adsb_ppm_tx

Overview:
- Mode-S / ADS-B PPM waveform generator: the transmit-side counterpart of the adsb_rx detector chain.
- Builds a 56- or 112-bit squitter from four 32-bit words loaded over the SPI register bus. Emits an 8 us preamble followed by 1 Mbit/s PPM data.
- Output is a 10-bit log-magnitude sample stream that can replace the reclocked ADC data as a loopback/self-test source for adsb_rx, plus a 1-bit envelope for an external modulator.

Parameters:
- width, 10, bit width of logmag samples and level inputs
- CHIP_CLKS, 10, enabled clocks per 0.5 us chip (20 MHz clock)
- TAIL_CHIPS, 8, quiet chips appended after the last data bit before done

Ports:
- clk  in  1  system clock, 20 MHz
- reset  in  1  synchronous, active-high
- ena  in  1  sample enable; all timing counters advance only when high
- load  in  1  single-cycle pulse: write wdat into message buffer at wr_ptr
- wdat  in  32  message word, MSB transmitted first
- start  in  1  single-cycle pulse: begin transmission
- long_msg  in  1  1 = 112 bits, 0 = 56 bits; sampled at start
- hi_level  in  width  logmag value for pulse-on chips
- lo_level  in  width  logmag value for pulse-off chips and idle
- logmag  out  width  registered sample stream
- env  out  1  registered on/off envelope
- busy  out  1  high from start acceptance until done
- done  out  1  single-cycle pulse at end of tail
- wr_ptr  out  2  next buffer word index, for register readback

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: logmag=0, env=0, busy=0, done=0, wr_ptr=0, state=IDLE, all counters 0. Buffer contents are not cleared.
- Buffer: 4 x 32-bit words, word0..word3.
  - A load in IDLE writes buf[wr_ptr] and then increments wr_ptr modulo 4. A fifth load overwrites word0.
  - A load while busy is ignored; neither buffer nor wr_ptr changes.
- Bit order: word0[31] is sent first, then down through word3[16] (112 bits) or word1[8] (56 bits).
- start in IDLE is accepted:
  - Buffer is snapshotted into a 112-bit shift register.
  - long_msg is latched; busy is set on the next clock; wr_ptr is cleared to 0.
  - start in any other state is ignored.
- Simultaneous load+start in IDLE: the load updates the buffer and wr_ptr, then wr_ptr is cleared by start. The snapshot uses pre-write buffer contents.
- States:
  - IDLE: output lo_level, env=0.
  - PRE: 16 chips. Chips 0, 2, 7, 9 are on; all others off.
  - DATA: 2 chips per bit. Bit=1 gives on,off; bit=0 gives off,on. 56 or 112 bits.
  - TAIL: TAIL_CHIPS chips, all off.
  - At the end of TAIL: done=1 for one clk, busy=0 on the same clock, state returns to IDLE.
- Chip timing:
  - The chip counter counts 0..CHIP_CLKS-1 on ena and wraps.
  - The chip index advances on wrap.
  - Transitions occur on the last enabled clock of the final chip.
- Latency: the start pulse is on clock N. With ena held high, the first preamble on-sample appears at logmag/env on clock N+1. Each chip lasts exactly CHIP_CLKS ena cycles.
- Total busy duration with ena=1 and defaults:
  - 112-bit: (16+224+8)*10 = 2480 clocks
  - 56-bit: (16+112+8)*10 = 1360 clocks
- ena low: all counters and logmag/env hold their value. done is never asserted while ena=0.
- Levels: hi_level and lo_level are sampled every clock, not latched; logmag = env ? hi_level : lo_level, registered.
- Reset mid-transmission: immediately IDLE, outputs return to reset values, no done pulse.

Test Plan:
- Load 0x8D4840D6, 0x202CC371, 0xC32CE057, 0x6098xxxx; start with long_msg=1, hi=600, lo=40 -> env on at chip offsets 0, 2, 7, 9 (clocks N+1..N+10, N+21..N+30, ...). Data chips match the bits MSB-first (first bit 1 = on,off). done at exactly N+2480; a captured adsb_rx loopback decode equals the loaded 112 bits.
- long_msg=0, word0=0xFFFFFFFF, word1=0x00000000 -> 32 on-off pairs, then 24 off-on pairs; done 1360 clocks after start; busy high throughout.
- ena toggling 1-of-2 clocks during transmission -> waveform identical when sampled on ena, total duration 2x; done only on an ena cycle.
- Loads and starts during busy -> wr_ptr and buffer unchanged, no restart, single done. Five loads in IDLE -> word0 holds the fifth value, wr_ptr=1.
- Load+start on the same cycle -> transmitted word0 is the old value, buffer holds the new one, wr_ptr=0 after.
- Reset asserted at clock 500 of a transmission -> next clock logmag=0, env=0, busy=0, no done. A subsequent start transmits the unchanged buffer.
